// File: rtl/param_data_memory_pkg.sv
// Shared definitions for the parameterised data memory: controller states and default sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package param_data_memory_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 256;

  // CLEAR: zeroing sweep in progress, requests blocked. READY: serving requests.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/dm_sram_array.sv
// Storage array: one synchronous write port and one synchronous read port, no reset.
// Latency: write lands on the clock edge; read data registered one edge after re.
// Backpressure: none; the port is always available, rdata holds while re is low.
//
// Ports: clock; we/waddr/wdata write port; re/raddr read request; rdata registered read data.
module dm_sram_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/param_data_memory.sv
// Single-port request/response data memory with a full-array zeroing sweep after reset or on demand.
// Latency: one cycle from request acceptance to the rsp_valid pulse; a sweep takes DEPTH cycles.
// Backpressure: req_ready is low for the whole sweep; responses cannot be stalled.
//
// Ports: clock, reset_n (async active-low); req_valid/req_ready/req_write/req_addr/req_wdata
// request channel; rsp_valid/rsp_rdata/rsp_err response; clear_start/clear_busy sweep control.
module param_data_memory
  import param_data_memory_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              clear_start,
  output logic              clear_busy
);

  localparam int CNT_W = $clog2(DEPTH);
  // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              accept;
  logic              in_range;
  logic              rd_sel;
  logic              mem_we;
  logic [CNT_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  assign req_ready  = (state == READY);
  assign clear_busy = (state == CLEAR);
  assign accept     = req_valid & req_ready;
  assign in_range   = ({1'b0, req_addr} < DEPTH_EXT);
  assign mem_re     = accept & ~req_write & in_range;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The write port belongs to the sweep in CLEAR and to the request path in READY.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_we    = 1'b0;
    mem_waddr = cnt;
    mem_wdata = '0;
    case (state)
      CLEAR: begin
        mem_we = 1'b1;
        if (cnt == LAST_IDX) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      READY: begin
        mem_we    = accept & req_write & in_range;
        mem_waddr = req_addr[CNT_W-1:0];
        mem_wdata = req_wdata;
        if (clear_start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  // rd_sel records whether the last response carried array data; otherwise the response
  // data is forced to zero. Both the array read register and rd_sel only move on acceptance,
  // so rsp_rdata naturally holds between responses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rd_sel    <= 1'b0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept & ~in_range;
      if (accept) begin
        rd_sel <= ~req_write & in_range;
      end
    end
  end

  assign rsp_rdata = rd_sel ? mem_rdata : '0;

  dm_sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (CNT_W)
  ) u_array (
    .clock  (clock),
    .we     (mem_we),
    .waddr  (mem_waddr),
    .wdata  (mem_wdata),
    .re     (mem_re),
    .raddr  (req_addr[CNT_W-1:0]),
    .rdata  (mem_rdata)
  );

endmodule

// File: tb/tb_param_data_memory.sv
// Bench for param_data_memory: default 256-word instance checked against a behavioural model,
// plus a 200-word instance sharing the same stimulus for out-of-range behaviour.
// Latency/backpressure: inherited from the design.
module tb_param_data_memory;

  localparam int DEPTH = 256;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       clear_start = 1'b0;

  logic       req_ready, rsp_valid, rsp_err, clear_busy;
  logic [7:0] rsp_rdata;
  logic       d2_req_ready, d2_rsp_valid, d2_rsp_err, d2_clear_busy;
  logic [7:0] d2_rsp_rdata;

  always #5 clock = ~clock;

  param_data_memory dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .clear_start (clear_start),
    .clear_busy  (clear_busy)
  );

  param_data_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(200)) dut200 (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (d2_req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (d2_rsp_valid),
    .rsp_rdata   (d2_rsp_rdata),
    .rsp_err     (d2_rsp_err),
    .clear_start (clear_start),
    .clear_busy  (d2_clear_busy)
  );

  // Behavioural model of the 256-word instance.
  logic [7:0] mem_m [DEPTH];
  int         m_busy_left;
  logic       m_vld;
  logic       m_err;
  logic [7:0] m_held;
  int         n_acc, n_rsp;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // One clock: update the model with the currently driven inputs, cross the edge, compare.
  task automatic step();
    bit acc;
    acc = req_valid && (m_busy_left == 0);
    if (acc) begin
      n_acc++;
      m_vld = 1'b1;
      m_err = (int'(req_addr) >= DEPTH);
      if (req_write) begin
        m_held = 8'h00;
        mem_m[req_addr] = req_wdata;
      end else begin
        m_held = mem_m[req_addr];
      end
    end else begin
      m_vld = 1'b0;
    end
    if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
      end
    end else if (clear_start) begin
      m_busy_left = DEPTH;
    end
    @(posedge clock);
    #1;
    if (rsp_valid) n_rsp++;
    chk("rsp_valid", rsp_valid, m_vld);
    chk("rsp_rdata", rsp_rdata, m_held);
    if (m_vld) chk("rsp_err", rsp_err, m_err);
    chk("req_ready", req_ready, m_busy_left == 0);
    chk("clear_busy", clear_busy, m_busy_left != 0);
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    req_valid   = 1'b0;
    clear_start = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_clear_busy", clear_busy, 1'b1);
    chk("rst_d2_clear_busy", d2_clear_busy, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_hold_rsp_valid", rsp_valid, 1'b0);
    chk("rst_hold_req_ready", req_ready, 1'b0);
    reset_n     = 1'b1;
    m_busy_left = DEPTH;
    m_held      = 8'h00;
    m_vld       = 1'b0;
  endtask

  task automatic drive(input logic wr, input logic [7:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  // Steps until the sweep ends; returns the number of cycles clear_busy was seen high.
  task automatic wait_sweep(output int n);
    n = 0;
    while (clear_busy && n < 400) begin
      step();
      n++;
    end
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int n;
    bit did;
    int acc0, rsp0;

    tbl[0] = '{1'b1, 8'h10, 8'hA5, 8'h00};
    tbl[1] = '{1'b0, 8'h10, 8'h00, 8'hA5};
    tbl[2] = '{1'b1, 8'h11, 8'h5A, 8'h00};
    tbl[3] = '{1'b0, 8'h11, 8'h00, 8'h5A};
    tbl[4] = '{1'b0, 8'h10, 8'h00, 8'hA5};
    tbl[5] = '{1'b1, 8'hFF, 8'h77, 8'h00};
    tbl[6] = '{1'b0, 8'hFF, 8'h00, 8'h77};
    tbl[7] = '{1'b0, 8'h00, 8'h00, 8'h00};
    tbl[8] = '{1'b1, 8'h00, 8'h01, 8'h00};
    tbl[9] = '{1'b0, 8'h00, 8'h00, 8'h01};

    n_acc = 0;
    n_rsp = 0;
    m_err = 1'b0;
    #2;

    // Power-up sweep length and a read of a cleared word.
    do_reset();
    wait_sweep(n);
    chk("initial_sweep_len", n, 256);
    drive(1'b0, 8'h7F, 8'h00);
    step();
    chk("read_7f_after_sweep", rsp_rdata, 8'h00);

    // Table vectors, back-to-back; each response lands one cycle after acceptance.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      step();
      chk("tbl_valid", rsp_valid, 1'b1);
      chk("tbl_rdata", rsp_rdata, tbl[i].exp_rdata);
      chk("tbl_err", rsp_err, 1'b0);
    end
    idle();
    step();
    chk("hold_rdata_after_read", rsp_rdata, 8'h01);

    // Write in the same cycle as clear_start: response issued, then a full sweep
    // (a second clear_start mid-sweep is ignored), then the word reads back zero.
    drive(1'b1, 8'h05, 8'h3C);
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    idle();
    chk("clr_write_rsp", rsp_valid, 1'b1);
    n = 0;
    while (!req_ready && n < 400) begin
      clear_start = (n == 50);
      step();
      n++;
    end
    clear_start = 1'b0;
    chk("clear_ready_low_len", n, 256);
    drive(1'b0, 8'h05, 8'h00);
    step();
    chk("read_05_after_clear", rsp_rdata, 8'h00);

    // Out-of-range handling on the 200-word instance (both arrays are freshly zeroed).
    drive(1'b1, 8'hC8, 8'h55);
    step();
    chk("d2_wr_c8_valid", d2_rsp_valid, 1'b1);
    chk("d2_wr_c8_err", d2_rsp_err, 1'b1);
    drive(1'b0, 8'hC8, 8'h00);
    step();
    chk("d2_rd_c8_err", d2_rsp_err, 1'b1);
    chk("d2_rd_c8_data", d2_rsp_rdata, 8'h00);
    drive(1'b0, 8'h00, 8'h00);
    step();
    chk("d2_rd_00_err", d2_rsp_err, 1'b0);
    chk("d2_rd_00_nowrap", d2_rsp_rdata, 8'h00);
    drive(1'b1, 8'hC7, 8'h66);
    step();
    drive(1'b0, 8'hC7, 8'h00);
    step();
    chk("d2_rd_c7_data", d2_rsp_rdata, 8'h66);
    chk("d2_rd_c7_err", d2_rsp_err, 1'b0);
    chk("d2_ready", d2_req_ready, 1'b1);

    // Reset while a response is showing, then reset again at sweep count 100;
    // a write offered mid-sweep must be ignored.
    drive(1'b0, 8'h10, 8'h00);
    step();
    chk("pre_reset_rsp", rsp_valid, 1'b1);
    do_reset();
    n = 0;
    did = 1'b0;
    while (clear_busy && n < 400) begin
      if (n == 100 && !did) begin
        do_reset();
        did = 1'b1;
        n = 0;
      end
      if (did && n == 150) drive(1'b1, 8'h10, 8'hEE);
      else idle();
      step();
      n++;
    end
    idle();
    chk("reset_resweep_len", n, 256);
    drive(1'b0, 8'h10, 8'h00);
    step();
    chk("sweep_ignores_req", rsp_rdata, 8'h00);

    // Random back-to-back traffic against the model.
    acc0 = n_acc;
    rsp0 = n_rsp;
    for (int i = 0; i < 50; i++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = 8'($urandom);
      drive(1'($urandom_range(0, 1)), a, 8'($urandom));
      step();
    end
    idle();
    step();
    chk("rand_rsp_count", n_rsp - rsp0, n_acc - acc0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
